// File: rtl/cordic_engine.sv
// cordic_engine: iterative circular CORDIC, vectoring or rotation per transaction, valid/ready on both sides.
// Define CORDIC_GAIN_COMP_EN to add a 1/K gain-compensation stage (one extra cycle of latency).
module cordic_engine #(
  parameter int WIDTH     = 16,
  parameter int ITERATION = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic                    i_mode,
  input  logic signed [WIDTH-1:0] ix,
  input  logic signed [WIDTH-1:0] iy,
  input  logic [31:0]             iz,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic signed [WIDTH+1:0] ox,
  output logic signed [WIDTH+1:0] oy,
  output logic [31:0]             oz
);

  localparam int XW = WIDTH + 2;
  localparam logic [3:0] LAST_ITER = 4'(ITERATION - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_ITER = 3'd2,
`ifdef CORDIC_GAIN_COMP_EN
    S_GAIN = 3'd3,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t                state_r;
  logic                  mode_r;
  logic [3:0]            iter_cnt_r;
  logic signed [XW-1:0]  x_r, y_r;
  logic [31:0]           z_r;
  logic                  i_ready_r, o_valid_r;
  logic signed [XW-1:0]  ox_r, oy_r;
  logic [31:0]           oz_r;

  logic                  pre_flip_s, d_pos_s;
  logic signed [XW-1:0]  x_sh_s, y_sh_s, x_nxt_s, y_nxt_s;
  logic [31:0]           atan_s, z_nxt_s;

  // atan(2^-i) in units of 2^32 per full turn
  function automatic logic [31:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 32'h2000_0000;
      4'd1:    atan_lut = 32'h12E4_051E;
      4'd2:    atan_lut = 32'h09FB_385B;
      4'd3:    atan_lut = 32'h0511_11D4;
      4'd4:    atan_lut = 32'h028B_0D43;
      4'd5:    atan_lut = 32'h0145_D7E1;
      4'd6:    atan_lut = 32'h00A2_F61E;
      4'd7:    atan_lut = 32'h0051_7C55;
      4'd8:    atan_lut = 32'h0028_BE53;
      4'd9:    atan_lut = 32'h0014_5F2F;
      4'd10:   atan_lut = 32'h000A_2F98;
      4'd11:   atan_lut = 32'h0005_17CC;
      4'd12:   atan_lut = 32'h0002_8BE6;
      4'd13:   atan_lut = 32'h0001_45F3;
      4'd14:   atan_lut = 32'h0000_A2FA;
      4'd15:   atan_lut = 32'h0000_517D;
      default: atan_lut = 32'h0000_0000;
    endcase
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [16:0]    INV_K    = 17'sh04DBA;
  localparam logic signed [XW+16:0] HALF_LSB = {{(XW+2){1'b0}}, 15'h4000};

  // Multiply by 1/K in Q1.15 and round half up back to the x/y width
  function automatic logic signed [XW-1:0] gain_scale(input logic signed [XW-1:0] v);
    logic signed [XW+16:0] prod;
    prod = (XW+17)'(v) * (XW+17)'(INV_K);
    prod = prod + HALF_LSB;
    gain_scale = prod[XW+14:15];
  endfunction
`endif

  // Fold into the right half-plane so the micro-rotations can converge
  always_comb begin
    pre_flip_s = mode_r ? (z_r[31] ^ z_r[30]) : x_r[XW-1];
  end

  // One micro-rotation for the current iteration index
  always_comb begin
    x_sh_s  = x_r >>> iter_cnt_r;
    y_sh_s  = y_r >>> iter_cnt_r;
    atan_s  = atan_lut(iter_cnt_r);
    d_pos_s = mode_r ? ~z_r[31] : y_r[XW-1];
    if (d_pos_s) begin
      x_nxt_s = x_r - y_sh_s;
      y_nxt_s = y_r + x_sh_s;
      z_nxt_s = z_r - atan_s;
    end else begin
      x_nxt_s = x_r + y_sh_s;
      y_nxt_s = y_r - x_sh_s;
      z_nxt_s = z_r + atan_s;
    end
  end

  // Transaction FSM with datapath and registered handshake/result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      mode_r     <= 1'b0;
      iter_cnt_r <= 4'd0;
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= 32'h0000_0000;
      i_ready_r  <= 1'b1;
      o_valid_r  <= 1'b0;
      ox_r       <= '0;
      oy_r       <= '0;
      oz_r       <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (i_valid && i_ready_r) begin
            x_r        <= {{2{ix[WIDTH-1]}}, ix};
            y_r        <= {{2{iy[WIDTH-1]}}, iy};
            z_r        <= iz;
            mode_r     <= i_mode;
            iter_cnt_r <= 4'd0;
            i_ready_r  <= 1'b0;
            state_r    <= S_PRE;
          end
        end
        S_PRE: begin
          if (pre_flip_s) begin
            x_r <= -x_r;
            y_r <= -y_r;
            z_r <= z_r + 32'h8000_0000;
          end
          state_r <= S_ITER;
        end
        S_ITER: begin
          x_r <= x_nxt_s;
          y_r <= y_nxt_s;
          z_r <= z_nxt_s;
          if (iter_cnt_r == LAST_ITER) begin
            iter_cnt_r <= 4'd0;
`ifdef CORDIC_GAIN_COMP_EN
            state_r    <= S_GAIN;
`else
            ox_r       <= x_nxt_s;
            oy_r       <= y_nxt_s;
            oz_r       <= z_nxt_s;
            o_valid_r  <= 1'b1;
            state_r    <= S_DONE;
`endif
          end else begin
            iter_cnt_r <= iter_cnt_r + 4'd1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        S_GAIN: begin
          ox_r      <= gain_scale(x_r);
          oy_r      <= gain_scale(y_r);
          oz_r      <= z_r;
          o_valid_r <= 1'b1;
          state_r   <= S_DONE;
        end
`endif
        S_DONE: begin
          if (o_ready) begin
            o_valid_r <= 1'b0;
            i_ready_r <= 1'b1;
            state_r   <= S_IDLE;
          end
        end
        default: begin
          o_valid_r  <= 1'b0;
          i_ready_r  <= 1'b1;
          iter_cnt_r <= 4'd0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

  assign i_ready = i_ready_r;
  assign o_valid = o_valid_r;
  assign ox      = ox_r;
  assign oy      = oy_r;
  assign oz      = oz_r;

endmodule
